dp_mod: RTL and testbench
=========================

Name: dp_mod

Overview:
- Digital FM/AM modulator datapath. Accepts a stream of 16-bit signed baseband samples and produces a 16-bit signed modulated sample stream.
- Built from a 24-bit phase accumulator (NCO), a sine ROM, and a single-multiplier AM envelope stage. Mode and all parameters are selectable per sample.
- Sits between the baseband sample source and the DAC/output formatter.

Parameters:
- PH_W, 24, phase accumulator and frec_por width.
- LUT_AW, 10, sine ROM address bits (phase MSBs used).
- D_W, 16, data, index and output width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_data  in  16  signed baseband sample.
- val_in  in  1  i_data and the parameters are valid this cycle.
- c_fm_am  in  1  mode: 0 = FM, 1 = AM.
- frec_por  in  24  unsigned carrier phase increment per sample; f = frec_por/2^24 · fs.
- im_am  in  16  unsigned AM modulation index.
- im_fm  in  16  unsigned FM modulation index.
- o_data  out  16  signed modulated sample.
- val_out  out  1  o_data is valid.

Behaviour:
- Reset (rst=0, async): phase accumulator, all pipeline registers, o_data and val_out go to 0.
- All inputs, including the parameters, are sampled only on cycles where val_in=1. Parameters may change every sample.
- Pipeline is 4 stages. The valid bit shifts every cycle regardless of val_in. val_out is val_in delayed by exactly 4 clocks; gaps are preserved.
- S1 (registers, taken when val_in=1):
  - p_fm = i_data × zero-extended im_fm, 32-bit signed.
  - p_am = i_data × zero-extended im_am, 32-bit signed (cannot overflow).
  - Also registers frec_por, mode and valid.
- S2, FM (mode 0):
  - inc = frec_por + (p_fm >>> 8), truncated to 24 bits, modulo 2^24.
- S2, AM (mode 1):
  - inc = frec_por.
  - env = 16384 + (p_am >>> 17), 17-bit signed, range 0..32767.
- S2, accumulator: when S1 is valid, acc <= acc + inc (24-bit wraparound). The phase forwarded to S3 is the updated acc value. The first sample after reset uses phase = inc.
- S3: synchronous ROM read. carrier = sin_lut[phase[23:14]].
  - sin_lut[k] = round(32767·sin(2πk/1024)), Q1.15.
- S4 output, FM: o_data <= carrier.
- S4 output, AM: o_data <= (carrier × env) >>> 15. Arithmetic shift, floor, no saturation needed.
- o_data updates only when the S3 valid bit is 1; otherwise it holds its last value.
- Idle cycles (val_in=0) do not advance the phase.
- Reset asserted mid-stream discards in-flight samples, clears acc to 0, and forces val_out=0 on the next cycle.

Decomposition:
- Package dp_mod_pkg holds:
  - width constants PH_W, LUT_AW, D_W;
  - mode encoding MODE_FM=0, MODE_AM=1;
  - the AM offset 16384;
  - the shift amounts 8, 17 and 15.
- Sub-module dp_mod_sin_rom: 1024×16 synchronous ROM, table generated from the formula above.
- NCO, multipliers and output stage stay in the top level.

Test Plan:
- Reset: hold rst=0 while driving val_in=1 -> o_data=0, val_out=0. Release rst -> first val_out exactly 4 clocks after the first valid input edge.
- FM, im_fm=0, frec_por=0x400000, i_data any, 8 valid samples -> o_data = 32767, 0, -32767, 0, repeating.
- AM, im_am=1000, i_data=0, frec_por=0x400000 -> o_data = 16383, 0, -16384, 0, repeating.
- AM envelope extremes, frec_por=0x400000, first sample, im_am=65535:
  - i_data=32767 -> 32766.
  - i_data=-32768 -> 0.
- FM deviation: frec_por=0, im_fm=256, i_data=16384 -> inc=16384 per sample. acc reaches 0x004000 after sample 1 -> index 1 -> o_data = sin_lut[1] = 201.
- Valid gaps and mid-stream reset:
  - Alternate val_in 1/0 -> val_out pattern identical, delayed 4 cycles; phase advances only on valid samples.
  - Pulse rst low mid-stream -> outputs cleared; restart begins at phase=inc.

Source files
------------

// File: rtl/dp_mod_pkg.sv
// dp_mod_pkg: shared constants, mode encoding and the sine table generator for
// the FM/AM modulator datapath.
package dp_mod_pkg;

  localparam int unsigned PH_W   = 24;  // phase accumulator / frequency word width
  localparam int unsigned LUT_AW = 10;  // sine ROM address bits
  localparam int unsigned D_W    = 16;  // sample, index and output width
  localparam int unsigned P_W    = 32;  // S1 product width
  localparam int unsigned ENV_W  = 17;  // AM envelope width (signed)

  typedef enum logic {
    MODE_FM = 1'b0,
    MODE_AM = 1'b1
  } mode_e;

  localparam int          AM_OFFSET    = 16384;
  localparam int unsigned FM_SHIFT     = 8;
  localparam int unsigned AM_ENV_SHIFT = 17;
  localparam int unsigned AM_OUT_SHIFT = 15;

  // round(32767 * sin(2*pi*idx/1024)) computed with a Q30 Taylor series over
  // the first quadrant and folded by symmetry. Only ever called with constant
  // arguments, so it reduces to a constant table.
  function automatic logic signed [D_W-1:0] sin_q15(input logic [LUT_AW-1:0] idx);
    longint m;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint res;
    m = longint'(idx[7:0]);
    if (idx[8]) m = 64'sd256 - m;
    // pi in Q30 times m/512 gives the first-quadrant angle in Q30
    x    = (m * 64'sd3373259426) / 64'sd512;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    res = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    if (idx[9]) res = -res;
    return D_W'(res);
  endfunction

endpackage

// File: rtl/dp_mod_sin_rom.sv
// dp_mod_sin_rom: 1024 x 16 synchronous sine ROM (Q1.15).
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset, clears the read register
//   i_en   - read enable; output register holds when low
//   i_addr - table index (phase MSBs)
//   o_data - registered signed sine sample
module dp_mod_sin_rom
  import dp_mod_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [D_W-1:0]    o_data
);

  logic [D_W-1:0] w_lut [1 << LUT_AW];

  for (genvar k = 0; k < (1 << LUT_AW); k++) begin : g_lut
    assign w_lut[k] = sin_q15(LUT_AW'(k));
  end

  logic [D_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_lut[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/dp_mod.sv
// dp_mod: FM/AM modulator datapath. 4-stage pipeline:
//   S1 multiplies the sample by both modulation indices,
//   S2 advances the 24-bit NCO and forms the AM envelope,
//   S3 reads the sine ROM, S4 selects / scales the carrier.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   i_data    - signed baseband sample
//   val_in    - sample and parameters valid
//   c_fm_am   - mode, 0 = FM, 1 = AM
//   frec_por  - carrier phase increment per sample
//   im_am     - unsigned AM modulation index
//   im_fm     - unsigned FM modulation index
//   o_data    - signed modulated sample
//   val_out   - o_data valid (val_in delayed by 4 clocks)
module dp_mod
  import dp_mod_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [D_W-1:0]  i_data,
  input  logic            val_in,
  input  logic            c_fm_am,
  input  logic [PH_W-1:0] frec_por,
  input  logic [D_W-1:0]  im_am,
  input  logic [D_W-1:0]  im_fm,
  output logic [D_W-1:0]  o_data,
  output logic            val_out
);

  // ---------------- S1: products ----------------
  logic signed [P_W-1:0] w_p_fm;
  logic signed [P_W-1:0] w_p_am;

  // Only the low 32 bits are kept; the indices are zero-extended so the
  // product is a signed x unsigned multiply.
  assign w_p_fm = P_W'($signed(i_data)) * $signed(P_W'(im_fm));
  assign w_p_am = P_W'($signed(i_data)) * $signed(P_W'(im_am));

  logic signed [P_W-1:0] r1_p_fm;
  logic signed [P_W-1:0] r1_p_am;
  logic [PH_W-1:0]       r1_frec;
  mode_e                 r1_mode;
  logic                  r1_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_p_fm <= '0;
      r1_p_am <= '0;
      r1_frec <= '0;
      r1_mode <= MODE_FM;
      r1_val  <= 1'b0;
    end else begin
      r1_val <= val_in;
      if (val_in) begin
        r1_p_fm <= w_p_fm;
        r1_p_am <= w_p_am;
        r1_frec <= frec_por;
        r1_mode <= mode_e'(c_fm_am);
      end
    end
  end

  // ---------------- S2: NCO and envelope ----------------
  logic [PH_W-1:0]         w_inc;
  logic signed [ENV_W-1:0] w_env;

  always_comb begin
    w_inc = r1_frec;
    if (r1_mode == MODE_FM) begin
      w_inc = r1_frec + PH_W'(r1_p_fm >>> FM_SHIFT);
    end
  end

  assign w_env = ENV_W'(AM_OFFSET) + ENV_W'(r1_p_am >>> AM_ENV_SHIFT);

  logic [PH_W-1:0]         r_acc;
  logic signed [ENV_W-1:0] r2_env;
  mode_e                   r2_mode;
  logic                    r2_val;

  // r_acc is the updated phase and doubles as the S2->S3 phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r2_env  <= '0;
      r2_mode <= MODE_FM;
      r2_val  <= 1'b0;
    end else begin
      r2_val <= r1_val;
      if (r1_val) begin
        r_acc   <= r_acc + w_inc;
        r2_env  <= w_env;
        r2_mode <= r1_mode;
      end
    end
  end

  // ---------------- S3: sine ROM ----------------
  logic [D_W-1:0]          w_carrier;
  logic signed [ENV_W-1:0] r3_env;
  mode_e                   r3_mode;
  logic                    r3_val;

  dp_mod_sin_rom u_sin_rom (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r2_val),
    .i_addr (r_acc[PH_W-1 -: LUT_AW]),
    .o_data (w_carrier)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r3_env  <= '0;
      r3_mode <= MODE_FM;
      r3_val  <= 1'b0;
    end else begin
      r3_val <= r2_val;
      if (r2_val) begin
        r3_env  <= r2_env;
        r3_mode <= r2_mode;
      end
    end
  end

  // ---------------- S4: output ----------------
  logic signed [ENV_W+D_W-1:0] w_am_prod;
  logic [D_W-1:0]              w_am_out;

  assign w_am_prod = (ENV_W+D_W)'($signed(w_carrier)) * (ENV_W+D_W)'(r3_env);
  // Envelope is at most 32767, so the floored result always fits 16 bits.
  assign w_am_out  = D_W'(w_am_prod >>> AM_OUT_SHIFT);

  logic [D_W-1:0] r_out;
  logic           r_val_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= '0;
      r_val_out <= 1'b0;
    end else begin
      r_val_out <= r3_val;
      if (r3_val) begin
        r_out <= (r3_mode == MODE_AM) ? w_am_out : w_carrier;
      end
    end
  end

  assign o_data  = r_out;
  assign val_out = r_val_out;

endmodule

// File: tb/tb_dp_mod.sv
module tb_dp_mod;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i_data = '0;
  logic        val_in = 1'b0;
  logic        c_fm_am = 1'b0;
  logic [23:0] frec_por = '0;
  logic [15:0] im_am = '0;
  logic [15:0] im_fm = '0;
  logic [15:0] o_data;
  logic        val_out;

  dp_mod dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .val_in   (val_in),
    .c_fm_am  (c_fm_am),
    .frec_por (frec_por),
    .im_am    (im_am),
    .im_fm    (im_fm),
    .o_data   (o_data),
    .val_out  (val_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic [23:0] frec;
    logic [15:0] ima;
    logic [15:0] imf;
    int          exp;
  } vec_t;

  vec_t vecs[24];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic [15:0] d,
                       input logic [23:0] f, input logic [15:0] ia, input logic [15:0] ifm);
    val_in   = v;
    c_fm_am  = m;
    i_data   = d;
    frec_por = f;
    im_am    = ia;
    im_fm    = ifm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    val_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Streams vecs[lo..hi] back to back after a reset and checks each result
  // 4 clocks after its input.
  task automatic apply_group(input int lo, input int hi);
    int n;
    n = hi - lo + 1;
    do_reset();
    for (int c = 0; c < n + 4; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        chk($sformatf("vec%0d_val", lo + c - 4), int'(val_out), 1);
        chk($sformatf("vec%0d_data", lo + c - 4), int'($signed(o_data)), vecs[lo + c - 4].exp);
      end
      if (c < n) begin
        drive(1'b1, vecs[lo + c].mode, vecs[lo + c].data, vecs[lo + c].frec,
              vecs[lo + c].ima, vecs[lo + c].imf);
      end else begin
        val_in = 1'b0;
      end
    end
  endtask

  initial begin
    int cnt;
    int k;
    int exp_o;
    logic hist[16];
    int pat[4];

    // FM carrier only, i_data ignored since im_fm = 0
    vecs[0]  = '{1'b0, 16'h1234, 24'h400000, 16'd0, 16'd0, 32767};
    vecs[1]  = '{1'b0, 16'h8000, 24'h400000, 16'd0, 16'd0, 0};
    vecs[2]  = '{1'b0, 16'h7fff, 24'h400000, 16'd0, 16'd0, -32767};
    vecs[3]  = '{1'b0, 16'h0000, 24'h400000, 16'd0, 16'd0, 0};
    vecs[4]  = '{1'b0, 16'hff00, 24'h400000, 16'd0, 16'd0, 32767};
    vecs[5]  = '{1'b0, 16'h0001, 24'h400000, 16'd0, 16'd0, 0};
    vecs[6]  = '{1'b0, 16'h5555, 24'h400000, 16'd0, 16'd0, -32767};
    vecs[7]  = '{1'b0, 16'haaaa, 24'h400000, 16'd0, 16'd0, 0};
    // AM, zero sample: half-scale carrier, floor on negative peak
    vecs[8]  = '{1'b1, 16'h0000, 24'h400000, 16'd1000, 16'd0, 16383};
    vecs[9]  = '{1'b1, 16'h0000, 24'h400000, 16'd1000, 16'd0, 0};
    vecs[10] = '{1'b1, 16'h0000, 24'h400000, 16'd1000, 16'd0, -16384};
    vecs[11] = '{1'b1, 16'h0000, 24'h400000, 16'd1000, 16'd0, 0};
    // AM envelope extremes, then back to FM
    vecs[12] = '{1'b1, 16'h7fff, 24'h400000, 16'hffff, 16'd0, 32766};
    vecs[13] = '{1'b1, 16'h8000, 24'h000000, 16'hffff, 16'd0, 0};
    vecs[14] = '{1'b1, 16'h0000, 24'h000000, 16'd0, 16'd0, 16383};
    vecs[15] = '{1'b1, 16'h7fff, 24'h800000, 16'hffff, 16'd0, -32767};
    vecs[16] = '{1'b0, 16'h0000, 24'h400000, 16'd0, 16'd0, 0};
    // FM deviation: +/-0x4000 per sample, including wrap below zero
    vecs[17] = '{1'b0, 16'h4000, 24'h000000, 16'd0, 16'd256, 201};
    vecs[18] = '{1'b0, 16'h4000, 24'h000000, 16'd0, 16'd256, 402};
    vecs[19] = '{1'b0, 16'h4000, 24'h000000, 16'd0, 16'd256, 603};
    vecs[20] = '{1'b0, 16'hc000, 24'h000000, 16'd0, 16'd256, 402};
    vecs[21] = '{1'b0, 16'hc000, 24'h000000, 16'd0, 16'd256, 201};
    vecs[22] = '{1'b0, 16'hc000, 24'h000000, 16'd0, 16'd256, 0};
    vecs[23] = '{1'b0, 16'hc000, 24'h000000, 16'd0, 16'd256, -201};

    // Reset held while valid inputs are driven
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h1234, 24'h400000, 16'd0, 16'd0);
    repeat (6) @(negedge clk);
    chk("rst_val_out", int'(val_out), 0);
    chk("rst_o_data", int'($signed(o_data)), 0);

    // Release: first val_out exactly 4 clocks after the first valid edge
    rst = 1'b1;
    cnt = 0;
    while (!val_out && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_latency", cnt, 4);
    chk("first_phase_is_inc", int'($signed(o_data)), 32767);
    val_in = 1'b0;

    apply_group(0, 7);
    apply_group(8, 11);
    apply_group(12, 16);
    apply_group(17, 23);

    // Alternating valid gaps: val_out mirrors val_in 4 clocks later and the
    // phase only moves on valid samples, so the output holds across gaps.
    pat = '{32767, 0, -32767, 0};
    do_reset();
    k     = 0;
    exp_o = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        if (hist[c - 4]) begin
          exp_o = pat[k % 4];
          k++;
        end
        chk($sformatf("gap%0d_val", c), int'(val_out), int'(hist[c - 4]));
        chk($sformatf("gap%0d_data", c), int'($signed(o_data)), exp_o);
      end
      hist[c] = (c < 8) && (c % 2 == 0);
      drive(hist[c], 1'b0, 16'h0000, 24'h400000, 16'd0, 16'd0);
    end
    val_in = 1'b0;

    // Mid-stream reset: clears outputs asynchronously and restarts the NCO
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0000, 24'h300000, 16'd0, 16'd0);
    end
    @(negedge clk);
    chk("pre_rst_val", int'(val_out), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_val", int'(val_out), 0);
    chk("mid_rst_data", int'($signed(o_data)), 0);
    @(negedge clk);
    rst    = 1'b1;
    val_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("flushed_val", int'(val_out), 0);
    drive(1'b1, 1'b0, 16'h0000, 24'h400000, 16'd0, 16'd0);
    @(negedge clk);
    val_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_val", int'(val_out), 1);
    chk("restart_data", int'($signed(o_data)), 32767);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
